// File: rtl/lsu_mem_ctrl.sv
// Load/store bridge between the core's single-cycle memory port and a
// handshaked data-memory bus: lane steering, stall generation, misalign/timeout flags.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        req, mis_now;
  logic [3:0]  be_now;
  logic [31:0] wd_now;
  logic [31:0] shifted, load_data;
  logic [1:0]  lane_q, size_q;
  logic [15:0] cnt;

  always_comb begin
    req = mem_read | mem_write;
    mis_now = 1'b0;
    be_now = 4'b1111;
    wd_now = wdata;
    case (size)
      2'b00: begin
        be_now = 4'b0001 << addr[1:0];
        wd_now = {4{wdata[7:0]}};
      end
      2'b01: begin
        mis_now = addr[0];
        be_now = 4'b0011 << {addr[1], 1'b0};
        wd_now = {2{wdata[15:0]}};
      end
      default: mis_now = |addr[1:0];
    endcase
  end

  // Sub-word loads land at bit 0 with everything above the lane cleared.
  always_comb begin
    shifted = bus_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {24'h0, shifted[7:0]};
      2'b01:   load_data = {16'h0, shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall = 1'b0;
    bus_req = 1'b0;
    case (state)
      IDLE: begin
        stall = req & ~mis_now;
        if (req && !mis_now) state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Core must not be held by a request that reset is already discarding.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata     <= '0;
      misalign  <= 1'b0;
      fault     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      cnt       <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req && mis_now) begin
            misalign <= 1'b1;
            rdata    <= '0;
          end else if (req) begin
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_now;
            bus_wdata <= wd_now;
            lane_q    <= addr[1:0];
            size_q    <= size;
            cnt       <= '0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) rdata <= load_data;
          end else if (cnt == CNT_LAST) begin
            fault <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
